// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and state encoding for fetch_stage and mainmem
package fetch_pkg;

  // Reset PC and base address of main memory.
  localparam logic [31:0] STARTING_ADDR   = 32'h0100_0000;
  // Size of main memory in bytes; PCs at or beyond STARTING_ADDR + MEM_DEPTH_BYTES fault.
  localparam logic [31:0] MEM_DEPTH_BYTES = 32'h0010_0000;

  // mainmem read_write encoding.
  localparam logic READ  = 1'b0;
  localparam logic WRITE = 1'b1;

  // Environment call: fetch stops after emitting this word.
  localparam logic [31:0] INSN_ECALL = 32'h0000_0073;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2,
    TRAP   = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC, mainmem read, registered {pc, insn} to decode
//
// Ports:
//   clock, reset_n               - clock, asynchronous active-low reset
//   mem_address, mem_read_write  - to mainmem (address = PC register, always READ)
//   mem_data_out                 - combinational read data from mainmem
//   redirect_valid, redirect_pc  - branch/jump redirect request and target
//   f_valid, f_ready, f_pc, f_insn - valid/ready output pair to decode
//   halted                       - ecall emitted, fetch stopped until redirect
//   fetch_error                  - sticky fault on misaligned/out-of-range PC
module fetch_stage
  import fetch_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  output logic [31:0] mem_address,
  output logic        mem_read_write,
  input  logic [31:0] mem_data_out,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        f_valid,
  input  logic        f_ready,
  output logic [31:0] f_pc,
  output logic [31:0] f_insn,
  output logic        halted,
  output logic        fetch_error
);

  localparam logic [1:0] S_BOOT   = BOOT;
  localparam logic [1:0] S_FETCH  = FETCH;
  localparam logic [1:0] S_HALTED = HALTED;
  localparam logic [1:0] S_TRAP   = TRAP;

  // Misaligned, below the memory base, or at/after its end. The subtraction
  // is only meaningful once pc >= STARTING_ADDR, which the second term guards.
  function automatic logic pc_faults(input logic [31:0] pc);
    logic [31:0] offset;
    offset = pc - STARTING_ADDR;
    return (pc[1:0] != 2'b00) || (pc < STARTING_ADDR) || (offset >= MEM_DEPTH_BYTES);
  endfunction

  logic [1:0]  state_q,       state_d;
  logic [31:0] pc_q,          pc_d;
  logic        f_valid_q,     f_valid_d;
  logic [31:0] f_pc_q,        f_pc_d;
  logic [31:0] f_insn_q,      f_insn_d;
  logic        halted_q,      halted_d;
  logic        fetch_error_q, fetch_error_d;

  logic slot_free;
  assign slot_free = !f_valid_q || f_ready;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    f_valid_d     = f_valid_q;
    f_pc_d        = f_pc_q;
    f_insn_d      = f_insn_q;
    halted_d      = halted_q;
    fetch_error_d = fetch_error_q;

    if (state_q != S_TRAP && redirect_valid) begin
      // Flush whatever is waiting for decode, even if decode is stalled.
      pc_d      = redirect_pc;
      f_valid_d = 1'b0;
      state_d   = S_FETCH;
      halted_d  = 1'b0;
    end else begin
      case (state_q)
        S_BOOT: begin
          state_d = S_FETCH;
        end
        S_FETCH: begin
          if (pc_faults(pc_q)) begin
            state_d       = S_TRAP;
            fetch_error_d = 1'b1;
            if (f_ready) f_valid_d = 1'b0;
          end else if (slot_free) begin
            f_pc_d    = pc_q;
            f_insn_d  = mem_data_out;
            f_valid_d = 1'b1;
            pc_d      = pc_q + 32'd4;
            if (mem_data_out == INSN_ECALL) begin
              state_d  = S_HALTED;
              halted_d = 1'b1;
            end
          end
        end
        default: begin
          // HALTED and TRAP only let the pending pair drain.
          if (f_ready) f_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_BOOT;
      pc_q          <= STARTING_ADDR;
      f_valid_q     <= 1'b0;
      f_pc_q        <= 32'd0;
      f_insn_q      <= 32'd0;
      halted_q      <= 1'b0;
      fetch_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      f_valid_q     <= f_valid_d;
      f_pc_q        <= f_pc_d;
      f_insn_q      <= f_insn_d;
      halted_q      <= halted_d;
      fetch_error_q <= fetch_error_d;
    end
  end

  assign mem_address    = pc_q;
  assign mem_read_write = READ;
  assign f_valid        = f_valid_q;
  assign f_pc           = f_pc_q;
  assign f_insn         = f_insn_q;
  assign halted         = halted_q;
  assign fetch_error    = fetch_error_q;

endmodule
